// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: runtime configuration, serial input stream and match outputs.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cfg_mealy;
  logic             en;
  logic             din;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic             armed;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_mealy, en, din,
    input  match, match_cnt, cfg_err, armed
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_mealy, en, din,
    output match, match_cnt, cfg_err, armed
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (overlap/non-overlap, Mealy/Moore output).
// Optional match counter is built only when SEQDET_MATCH_CNT_EN is defined; otherwise match_cnt is 0.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detector_param_if.slave bus
);

  localparam logic [0:0]       UNCFG   = 1'b0;
  localparam logic [0:0]       SEARCH  = 1'b1;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [LEN_W:0]   PAT_W_X = (LEN_W+1)'(PAT_W);

  logic [0:0]       r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic             r_mealy;
  // The oldest history bit would only ever be shifted out, so it is not stored.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_match_p1;
  logic             r_cfg_err;

  logic             w_len_ok;
  logic             w_shift;
  logic [PAT_W-1:0] w_cand;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W:0]   w_fill_inc;
  logic [LEN_W-1:0] w_fill_nxt;
  logic             w_hit;

  assign w_len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= PAT_W_L);
  // A data bit arriving together with cfg_load is discarded.
  assign w_shift    = (r_state == SEARCH) && bus.en && !bus.cfg_load;
  assign w_cand     = {r_hist, bus.din};
  assign w_mask     = ~({PAT_W{1'b1}} << r_len);
  assign w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);
  assign w_fill_nxt = (w_fill_inc >= PAT_W_X) ? PAT_W_L : w_fill_inc[LEN_W-1:0];
  assign w_hit      = w_shift && (w_fill_inc >= {1'b0, r_len}) &&
                      ((w_cand & w_mask) == (r_pattern & w_mask));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= UNCFG;
      r_pattern  <= '0;
      r_len      <= '0;
      r_overlap  <= 1'b0;
      r_mealy    <= 1'b0;
      r_hist     <= '0;
      r_fill     <= '0;
      r_match_p1 <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      // Stage p1: Moore strobe; w_hit is 0 on idle and load cycles, which drops any pending match.
      r_match_p1 <= w_hit;
      r_cfg_err  <= bus.cfg_load && !w_len_ok;
      if (bus.cfg_load) begin
        if (w_len_ok) begin
          r_state   <= SEARCH;
          r_pattern <= bus.cfg_pattern;
          r_len     <= bus.cfg_len;
          r_overlap <= bus.cfg_overlap;
          r_mealy   <= bus.cfg_mealy;
          r_hist    <= '0;
          r_fill    <= '0;
        end
      end else if (w_shift) begin
        if (w_hit && !r_overlap) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_cand[PAT_W-2:0];
          r_fill <= w_fill_nxt;
        end
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.match_cnt = r_cnt;
`else
  assign bus.match_cnt = '0;
`endif

  assign bus.match   = r_mealy ? w_hit : r_match_p1;
  assign bus.cfg_err = r_cfg_err;
  assign bus.armed   = (r_state == SEARCH);

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector. It watches a 1-bit stream `din`, qualified by `en`, for a pattern loaded at runtime.
- Pattern length is programmable from 1 to PAT_W bits.
- Detection mode (overlapping or non-overlapping) and output style (Mealy or Moore) are selected at runtime.
- Used as the generic replacement for the fixed-pattern detectors in the FSM library; feeds a match strobe and a match count to downstream logic.

Parameters:
- PAT_W, 8, maximum pattern width in bits (>=2).
- LEN_W, $clog2(PAT_W)+1, width of the `cfg_len` field.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cfg_load  input  1  load strobe for cfg_pattern, cfg_len, cfg_overlap and cfg_mealy
- cfg_pattern  input  PAT_W  pattern; bit 0 = most recently received bit
- cfg_len  input  LEN_W  active pattern length, legal range 1..PAT_W
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_mealy  input  1  1 = Mealy (combinational) match output, 0 = Moore (registered) match output
- en  input  1  `din` is valid this cycle
- din  input  1  serial data bit
- match  output  1  1-cycle match strobe
- match_cnt  output  CNT_W  saturating count of matches
- cfg_err  output  1  1-cycle pulse when a cfg_load is rejected
- armed  output  1  1 when a legal configuration is active (state SEARCH)

Behaviour:
- Reset (asynchronous, applies immediately):
  - state=UNCFG; pattern/len/mode registers=0.
  - hist=0, fill=0.
  - match=0, match_cnt=0, cfg_err=0, armed=0.
- States:
  - UNCFG: `din` is ignored and match=0.
  - SEARCH: detection is active and armed=1.
- cfg_load, sampled at posedge clk:
  - If 1<=cfg_len<=PAT_W: latch all cfg_* inputs, clear hist and fill, go to SEARCH, clear any pending Moore match. Valid in either state, including mid-stream, where it restarts the search.
  - Otherwise: cfg_err=1 for the following cycle, and state and config are unchanged.
  - `en` in the same cycle as cfg_load is ignored; that bit is not shifted in.
- Candidate window: cand = {hist[PAT_W-2:0], din}.
- hit (combinational) = state==SEARCH && en && (fill+1 >= len) && cand[len-1:0]==pattern[len-1:0].
- On en=1 in SEARCH, at the clock edge:
  - If hit && !overlap: hist<=0 and fill<=0.
  - Otherwise: hist<=cand and fill<=min(fill+1, PAT_W).
- On en=0: hist and fill hold.
- Mealy match: match=hit, in the same cycle as the completing bit (zero latency).
- Moore match: registered, match=1 in the cycle after the hit, for exactly 1 cycle. The Moore register updates every cycle and captures 0 when en=0.
- Mode switch: a mode change takes effect only through cfg_load.
- Width rules:
  - fill is LEN_W wide and saturates at PAT_W.
  - Comparisons use the low `len` bits only; upper pattern bits are don't-care.
- Counter: match_cnt increments on the clock edge of each hit, independent of Mealy/Moore, and saturates at 2^CNT_W-1. It is not cleared by cfg_load, only by rst.
- Reset mid-operation: all state returns to reset values; a Moore match pending in the register is dropped.

Optional Feature:
- Macro: SEQDET_MATCH_CNT_EN.
- Defined: match_cnt is implemented as described above.
- Undefined: the counter logic is omitted and match_cnt is driven constant 0. All other behaviour is unchanged.

Test Plan:
- Pattern 3'b101, len=3, overlap=1, Mealy; stream 1,0,1,0,1 with en=1 -> match high in the same cycle as bits 3 and 5; match_cnt=2.
- Same stream, overlap=0 -> match only on bit 3; match_cnt=1; bits 4-5 ("01") do not match.
- Pattern 101, Moore, stream 1,0,1 -> match=0 during bit 3, match=1 in the next cycle for exactly 1 cycle. Pulsing en=0 between bits (1,-,0,-,1) still gives exactly 1 match.
- cfg_load with cfg_len=0, then cfg_len=PAT_W+1 -> cfg_err pulses 1 cycle each; armed stays 0 in UNCFG; din=1 stream gives match=0.
- CNT_W=2, pattern 1'b1 len=1 overlap=1, 5 consecutive 1s -> 5 matches, match_cnt saturates at 3. Then cfg_load -> match_cnt still 3.
- Pattern 1101 len=4, after bits 1,1,0 assert rst asynchronously mid-cycle -> outputs 0 immediately, armed=0. Reload and feed 1 -> no match, because fill was cleared.
